// File: rtl/spike_decoder_pkg.sv
// Shared types and constants for the spike class decoder: FSM state encoding
// and the character codes that map one-to-one onto the output neurons.
package spike_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_COUNT   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [1:0] CHAR_A = 2'b00;
   localparam logic [1:0] CHAR_J = 2'b01;
   localparam logic [1:0] CHAR_N = 2'b10;
   localparam logic [1:0] CHAR_X = 2'b11;

endpackage

// File: rtl/spike_edge_counter.sv
// One neuron lane: synchronizes an asynchronous spike line, detects 0->1
// transitions of the synchronized signal and counts them with saturation.
// clr has priority over en; the edge detector keeps tracking while disabled so
// a line that is already high when counting opens does not count as a spike.
module spike_edge_counter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spike,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;
   logic                   rise;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;

   // Synchronizer chain plus one extra flop holding the previous synchronized value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q[0] <= spike;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_out;
      end
   end

   // Saturating spike counter, cleared at the start of each classification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && rise && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/spike_class_decoder.sv
// Spike class decoder: after an accepted start it waits out a settle period,
// counts synchronized rising edges per neuron for a fixed window, then scans
// the counters one per cycle to find the winning neuron (lowest index on tie)
// and reports winner/count/tie/match with a one-cycle done pulse.
// Handshake: start is honoured only while idle and not in the done cycle;
// busy is high from the cycle after an accepted start until done pulses, and
// results hold until the next done.
module spike_class_decoder
   import spike_decoder_pkg::*;
#(
   parameter int NUM_NEURONS   = 4,
   parameter int WINDOW_CYCLES = 1000,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [1:0]             expected_char,
   input  logic [NUM_NEURONS-1:0] spikes,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             winner,
   output logic [CNT_W-1:0]       win_count,
   output logic                   tie,
   output logic                   match
);

   localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
   localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

   state_t             state;
   logic [SET_W-1:0]   settle_cnt;
   logic [WIN_W-1:0]   win_cnt;
   logic [IDX_W-1:0]   cmp_idx;
   logic [IDX_W-1:0]   max_idx;
   logic [CNT_W-1:0]   max_cnt;
   logic               tie_q;
   logic [1:0]         exp_char_q;
   logic               accept;
   logic               count_en;
   logic [CNT_W-1:0]   counts [NUM_NEURONS];
   logic [CNT_W-1:0]   cur_cnt;

   // A start landing in the done cycle is dropped even though state is already IDLE.
   assign accept   = (state == ST_IDLE) && start && !done;
   assign count_en = (state == ST_COUNT);
   assign cur_cnt  = counts[cmp_idx];

   for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
      spike_edge_counter #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .spike (spikes[g]),
         .clr   (accept),
         .en    (count_en),
         .count (counts[g])
      );
   end

   // Control FSM with settle/window timers, sequential argmax and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         win_cnt    <= '0;
         cmp_idx    <= '0;
         max_idx    <= '0;
         max_cnt    <= '0;
         tie_q      <= 1'b0;
         exp_char_q <= 2'b00;
         busy       <= 1'b0;
         done       <= 1'b0;
         winner     <= 2'b00;
         win_count  <= '0;
         tie        <= 1'b0;
         match      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  exp_char_q <= expected_char;
                  busy       <= 1'b1;
                  settle_cnt <= '0;
                  win_cnt    <= '0;
                  state      <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_COUNT;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SET_LAST) begin
                  state <= ST_COUNT;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_COUNT: begin
               if (win_cnt == WIN_LAST) begin
                  cmp_idx <= '0;
                  max_idx <= '0;
                  max_cnt <= '0;
                  tie_q   <= 1'b0;
                  state   <= ST_COMPARE;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            ST_COMPARE: begin
               // Starting from max=0, an all-zero bank ends with tie set and winner 0.
               if (cur_cnt > max_cnt) begin
                  max_cnt <= cur_cnt;
                  max_idx <= cmp_idx;
                  tie_q   <= 1'b0;
               end else if (cur_cnt == max_cnt) begin
                  tie_q <= 1'b1;
               end
               if (cmp_idx == IDX_LAST) begin
                  state <= ST_DONE;
               end else begin
                  cmp_idx <= cmp_idx + 1'b1;
               end
            end
            ST_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               winner    <= 2'(max_idx);
               win_count <= max_cnt;
               tie       <= tie_q;
               match     <= (2'(max_idx) == exp_char_q) && !tie_q;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_class_decoder.sv
// Directed bench for spike_class_decoder (WINDOW=16, SETTLE=2) plus a
// CNT_W=3 copy sharing the same inputs for the saturation case.
module tb_spike_class_decoder;

   localparam int EXP_W = 20;  // {winner[1:0], win_count[15:0], tie, match}
   localparam int LAT   = 1 + 2 + 16 + 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  expected_char = 2'b00;
   logic [3:0]  spikes = 4'b0000;

   logic        busy, done, tie, match;
   logic [1:0]  winner;
   logic [15:0] win_count;

   logic        s_busy, s_done, s_tie, s_match;
   logic [1:0]  s_winner;
   logic [2:0]  s_win_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [EXP_W-1:0] exp_q[$];

   // clock
   always #5 clk = ~clk;

   spike_class_decoder #(
      .NUM_NEURONS(4), .WINDOW_CYCLES(16), .SETTLE_CYCLES(2), .CNT_W(16), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .expected_char(expected_char),
      .spikes(spikes), .busy(busy), .done(done), .winner(winner),
      .win_count(win_count), .tie(tie), .match(match)
   );

   spike_class_decoder #(
      .NUM_NEURONS(4), .WINDOW_CYCLES(16), .SETTLE_CYCLES(2), .CNT_W(3), .SYNC_STAGES(2)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .expected_char(expected_char),
      .spikes(spikes), .busy(s_busy), .done(s_done), .winner(s_winner),
      .win_count(s_win_count), .tie(s_tie), .match(s_match)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Spike pattern for cycle c (c=0 is the negedge where start is raised).
   // A level set at cycle c is counted only for c in 1..16.
   function automatic logic [3:0] pat(input int mode, input int c);
      logic [3:0] p;
      p = 4'b0000;
      case (mode)
         1: if (c >= 1 && c <= 16 && ((c - 1) % 4) < 2) p[2] = 1'b1;
         2: if (c >= 1 && c <= 16 && ((c - 1) % 4) < 2) begin
               p[1] = 1'b1;
               p[3] = 1'b1;
            end
         3: if (c >= 1 && c <= 16 && ((c - 1) % 2) == 0) p[0] = 1'b1;
         4: begin
               if (c == 0) p[0] = 1'b1;              // lands in SETTLE
               if (c >= 17 && c <= 20) p[1] = 1'b1;  // lands just after the window
            end
         default: p = 4'b0000;
      endcase
      return p;
   endfunction

   // One classification: start at c=0, optional extra start and optional
   // reset pulse, 31 cycles observed; any done is scored against exp_q.
   task automatic run_case(input string name, input logic [1:0] ch, input int mode,
                           input int extra_start_c, input int abort_c, input int want_dones);
      int done_cnt;
      logic [EXP_W-1:0] e;
      done_cnt = 0;
      for (int c = 0; c <= 30; c++) begin
         @(negedge clk);
         start         = (c == 0) || (c == extra_start_c);
         expected_char = (c == 0) ? ch : ~ch;
         spikes        = pat(mode, c);
         if (c == abort_c)     rst_n = 1'b0;
         if (c == abort_c + 2) rst_n = 1'b1;
         #1;
         if (c == 1) check({name, " busy_after_start"}, 32'(busy), 32'd1);
         if (abort_c >= 0 && c == abort_c) begin
            check({name, " busy_in_reset"}, 32'(busy), 32'd0);
            check({name, " done_in_reset"}, 32'(done), 32'd0);
         end
         if (abort_c < 0 && c == 26) check({name, " busy_after_done"}, 32'(busy), 32'd0);
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               check({name, " latency"}, 32'(c - 1), 32'(LAT));
               check({name, " busy_low_at_done"}, 32'(busy), 32'd0);
               if (exp_q.size() == 0) begin
                  check({name, " unexpected_done"}, 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check({name, " winner"},    32'(winner),    32'(e[19:18]));
                  check({name, " win_count"}, 32'(win_count), 32'(e[17:2]));
                  check({name, " tie"},       32'(tie),       32'(e[1]));
                  check({name, " match"},     32'(match),     32'(e[0]));
               end
            end
         end
      end
      start  = 1'b0;
      spikes = 4'b0000;
      check({name, " done_count"}, 32'(done_cnt), 32'(want_dones));
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst busy",      32'(busy),      32'd0);
      check("rst done",      32'(done),      32'd0);
      check("rst winner",    32'(winner),    32'd0);
      check("rst win_count", 32'(win_count), 32'd0);
      check("rst tie",       32'(tie),       32'd0);
      check("rst match",     32'(match),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle spikes change nothing
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         spikes = 4'(i);
         #1;
         if (busy || done) check("idle quiet", 32'({busy, done}), 32'd0);
      end
      spikes = 4'b0000;
      check("idle win_count", 32'(win_count), 32'd0);
      check("idle busy",      32'(busy),      32'd0);

      // single winner on neuron 2, expected N
      exp_q.push_back({2'd2, 16'd4, 1'b0, 1'b1});
      run_case("t2", 2'b10, 1, -1, -1, 1);

      // tie between 1 and 3; start in the done cycle is ignored
      exp_q.push_back({2'd1, 16'd4, 1'b1, 1'b0});
      run_case("t3", 2'b11, 2, 24, -1, 1);
      repeat (3) @(negedge clk);
      #1;
      check("t3 hold winner", 32'(winner), 32'd1);
      check("t3 hold tie",    32'(tie),    32'd1);

      // 8 edges: full count on 16-bit copy, saturated on 3-bit copy
      exp_q.push_back({2'd0, 16'd8, 1'b0, 1'b1});
      run_case("t4", 2'b00, 3, -1, -1, 1);
      check("t4 sat win_count", 32'(s_win_count), 32'd7);
      check("t4 sat winner",    32'(s_winner),    32'd0);
      check("t4 sat tie",       32'(s_tie),       32'd0);
      check("t4 sat match",     32'(s_match),     32'd1);

      // start during COUNT ignored
      exp_q.push_back({2'd2, 16'd4, 1'b0, 1'b1});
      run_case("t5a", 2'b10, 1, 8, -1, 1);

      // reset mid-COUNT: no done, results cleared
      run_case("t5b", 2'b01, 1, -1, 10, 0);
      check("t5b winner",    32'(winner),    32'd0);
      check("t5b win_count", 32'(win_count), 32'd0);
      check("t5b match",     32'(match),     32'd0);

      // fresh run after abort
      exp_q.push_back({2'd2, 16'd4, 1'b0, 1'b1});
      run_case("t5c", 2'b10, 1, -1, -1, 1);

      // no spikes at all
      exp_q.push_back({2'd0, 16'd0, 1'b1, 1'b0});
      run_case("t6a", 2'b01, 0, -1, -1, 1);

      // edges only in SETTLE and just after the window
      exp_q.push_back({2'd0, 16'd0, 1'b1, 1'b0});
      run_case("t6b", 2'b01, 4, -1, -1, 1);

      check("exp_q drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
